// File: rtl/sram_fifo_pkg.sv
// Shared types and defaults for the SRAM-backed FIFO controller.
package sram_fifo_pkg;

    localparam int DWIDTH_DEF = 32;
    localparam int AWIDTH_DEF = 5;

    typedef enum logic [1:0] {
        OB_EMPTY = 2'd0,
        OB_ONE   = 2'd1,
        OB_TWO   = 2'd2
    } ob_state_t;

endpackage

// File: rtl/fifo_skid2.sv
// Two-entry registered output buffer fed by the SRAM read port.
module fifo_skid2
    import sram_fifo_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cap,
    input  logic [DWIDTH-1:0] i_data,
    input  logic              i_pop,
    output logic              o_valid,
    output logic [DWIDTH-1:0] o_data,
    output logic [1:0]        o_count
);

    ob_state_t         r_state;
    ob_state_t         w_state_nxt;
    logic [DWIDTH-1:0] r_e0;
    logic [DWIDTH-1:0] r_e1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= OB_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            OB_EMPTY: if (i_cap) w_state_nxt = OB_ONE;
            OB_ONE: begin
                if (i_cap && !i_pop) w_state_nxt = OB_TWO;
                else if (i_pop && !i_cap) w_state_nxt = OB_EMPTY;
            end
            OB_TWO: if (i_pop && !i_cap) w_state_nxt = OB_ONE;
            default: w_state_nxt = OB_EMPTY;
        endcase
    end

    // e0 is always the head; e1 only holds the second-oldest word
    always_ff @(posedge i_clk) begin
        case (r_state)
            OB_EMPTY: if (i_cap) r_e0 <= i_data;
            OB_ONE: begin
                if (i_cap && i_pop) r_e0 <= i_data;
                else if (i_cap) r_e1 <= i_data;
            end
            OB_TWO: begin
                if (i_pop) begin
                    r_e0 <= r_e1;
                    if (i_cap) r_e1 <= i_data;
                end
            end
            default: ;
        endcase
    end

    assign o_valid = (r_state != OB_EMPTY);
    assign o_data  = r_e0;
    assign o_count = r_state;

endmodule

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller around an external 1-cycle-latency dual-port SRAM.
module sram_fifo_ctrl
    import sram_fifo_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int AWIDTH = AWIDTH_DEF
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              wr_valid_in,
    input  logic [DWIDTH-1:0] wr_data_in,
    output logic              wr_ready_out,
    output logic              rd_valid_out,
    output logic [DWIDTH-1:0] rd_data_out,
    input  logic              rd_ready_in,
    output logic [AWIDTH:0]   count_out,
    output logic              full_out,
    output logic              empty_out,
    output logic              sram_en_a_out,
    output logic              sram_we_a_out,
    output logic [AWIDTH-1:0] sram_addr_a_out,
    output logic [DWIDTH-1:0] sram_d_a_out,
    output logic              sram_en_b_out,
    output logic              sram_we_b_out,
    output logic [AWIDTH-1:0] sram_addr_b_out,
    input  logic [DWIDTH-1:0] sram_d_b_in
);

    localparam int DEPTH = 2 ** AWIDTH;
    localparam logic [AWIDTH:0] L_DEPTH = (AWIDTH + 1)'(DEPTH);

    logic [AWIDTH-1:0] r_wptr;
    logic [AWIDTH-1:0] r_rptr;
    logic [AWIDTH:0]   r_mem_cnt;
    logic [AWIDTH:0]   r_count;
    logic              r_inflight;

    logic              w_push;
    logic              w_pop;
    logic              w_issue;
    logic [1:0]        w_ob_cnt;
    logic [2:0]        w_need;
    logic [2:0]        w_room;

    assign full_out     = (r_count == L_DEPTH);
    assign empty_out    = (r_count == '0);
    assign count_out    = r_count;
    assign wr_ready_out = !full_out && !rst_in;

    assign w_push = wr_valid_in && wr_ready_out;
    assign w_pop  = rd_valid_out && rd_ready_in;

    // never let buffered + in-flight words exceed the two buffer slots
    assign w_need  = {1'b0, w_ob_cnt} + {2'b00, r_inflight} + 3'd1;
    assign w_room  = 3'd2 + {2'b00, w_pop};
    assign w_issue = !rst_in && (r_mem_cnt != '0) && (w_need <= w_room);

    assign sram_en_a_out   = w_push;
    assign sram_we_a_out   = w_push;
    assign sram_addr_a_out = r_wptr;
    assign sram_d_a_out    = wr_data_in;
    assign sram_en_b_out   = w_issue;
    assign sram_we_b_out   = 1'b0;
    assign sram_addr_b_out = r_rptr;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_mem_cnt  <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_push) r_wptr <= r_wptr + AWIDTH'(1);
            if (w_issue) r_rptr <= r_rptr + AWIDTH'(1);
            case ({w_push, w_issue})
                2'b10:   r_mem_cnt <= r_mem_cnt + 1'b1;
                2'b01:   r_mem_cnt <= r_mem_cnt - 1'b1;
                default: r_mem_cnt <= r_mem_cnt;
            endcase
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    fifo_skid2 #(
        .DWIDTH (DWIDTH)
    ) u_skid (
        .i_clk   (clk_in),
        .i_rst   (rst_in),
        .i_cap   (r_inflight),
        .i_data  (sram_d_b_in),
        .i_pop   (w_pop),
        .o_valid (rd_valid_out),
        .o_data  (rd_data_out),
        .o_count (w_ob_cnt)
    );

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Scoreboard bench for sram_fifo_ctrl with a behavioural 1-cycle SRAM.
module tb_sram_fifo_ctrl;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_valid = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_ready = 1'b0;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          en_a, we_a, en_b, we_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] d_a;
    logic [DW-1:0] q_b;

    logic [DW-1:0] mem [DEPTH];

    int n_vec = 0;
    int n_bad = 0;
    int n_pop = 0;
    logic [DW-1:0] sb[$];

    always #5 clk = ~clk;

    sram_fifo_ctrl #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .wr_valid_in     (wr_valid),
        .wr_data_in      (wr_data),
        .wr_ready_out    (wr_ready),
        .rd_valid_out    (rd_valid),
        .rd_data_out     (rd_data),
        .rd_ready_in     (rd_ready),
        .count_out       (count),
        .full_out        (full),
        .empty_out       (empty),
        .sram_en_a_out   (en_a),
        .sram_we_a_out   (we_a),
        .sram_addr_a_out (addr_a),
        .sram_d_a_out    (d_a),
        .sram_en_b_out   (en_b),
        .sram_we_b_out   (we_b),
        .sram_addr_b_out (addr_b),
        .sram_d_b_in     (q_b)
    );

    always @(posedge clk) begin
        if (en_a && we_a) mem[addr_a] <= d_a;
        if (en_b) q_b <= mem[addr_b];
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            chk("count", 64'(count), 64'(sb.size()));
            if (we_b) chk("we_b", 64'(we_b), 64'd0);
            if (wr_valid && wr_ready) sb.push_back(wr_data);
            if (rd_valid && rd_ready) begin
                n_pop++;
                if (sb.size() == 0) chk("underflow", 64'(rd_data), 64'hx);
                else chk("data", 64'(rd_data), 64'(sb.pop_front()));
            end
        end
    end

    initial begin
        logic [DW-1:0] held;
        int idx;
        int budget;
        logic acc;

        cyc();
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_wrrdy", 64'(wr_ready), 64'd1);
        chk("rst_rdval", 64'(rd_valid), 64'd0);
        chk("rst_en", 64'({en_a, we_a, en_b, we_b}), 64'd0);

        // single word latency
        cyc();
        rd_ready = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 32'hA5A5_0001;
        @(negedge clk);
        chk("lat_c0", 64'(rd_valid), 64'd0);
        cyc();
        wr_valid = 1'b0;
        @(negedge clk);
        chk("lat_c1", 64'(rd_valid), 64'd0);
        @(negedge clk);
        chk("lat_c2", 64'(rd_valid), 64'd0);
        @(negedge clk);
        chk("lat_c3", 64'(rd_valid), 64'd1);
        chk("lat_data", 64'(rd_data), 64'hA5A5_0001);
        @(negedge clk);
        chk("lat_empty", 64'(empty), 64'd1);

        // fill with consumer stalled
        cyc();
        rd_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_valid = 1'b1;
            wr_data  = 32'(100 + i);
            cyc();
        end
        wr_data = 32'd999;
        @(negedge clk);
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_cnt", 64'(count), 64'(DEPTH));
        chk("fill_rdy", 64'(wr_ready), 64'd0);
        cyc();
        wr_valid = 1'b0;
        @(negedge clk);
        chk("fill_33", 64'(count), 64'(DEPTH));

        // backpressure with output buffer full
        held = rd_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_data", 64'(rd_data), 64'(held));
            chk("bp_enb", 64'(en_b), 64'd0);
            chk("bp_cnt", 64'(count), 64'(DEPTH));
        end

        // full with same-cycle pop: write refused, accepted next
        cyc();
        rd_ready = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 32'd500;
        @(negedge clk);
        chk("fp_rdy0", 64'(wr_ready), 64'd0);
        cyc();
        rd_ready = 1'b0;
        @(negedge clk);
        chk("fp_cnt31", 64'(count), 64'(DEPTH - 1));
        chk("fp_rdy1", 64'(wr_ready), 64'd1);
        cyc();
        wr_valid = 1'b0;
        @(negedge clk);
        chk("fp_cnt32", 64'(count), 64'(DEPTH));
        cyc();
        rd_ready = 1'b1;
        repeat (DEPTH + 8) cyc();
        @(negedge clk);
        chk("drain_empty", 64'(empty), 64'd1);

        // wrap with random consumer
        cyc();
        n_pop = 0;
        idx = 0;
        budget = 0;
        while ((idx < 100 || n_pop < 100) && budget < 3000) begin
            wr_valid = (idx < 100);
            wr_data  = 32'(idx);
            rd_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = wr_valid && wr_ready;
            cyc();
            if (acc) idx++;
            budget++;
        end
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        chk("wrap_pops", 64'(n_pop), 64'd100);
        chk("wrap_sb", 64'(sb.size()), 64'd0);

        // reset the cycle after a read issue
        wr_valid = 1'b1;
        wr_data  = 32'hDEAD_BEEF;
        cyc();
        wr_valid = 1'b0;
        budget = 0;
        @(negedge clk);
        while (!en_b && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        chk("rr_issue", 64'(en_b), 64'd1);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        rd_ready = 1'b1;
        @(negedge clk);
        chk("rr_cnt", 64'(count), 64'd0);
        chk("rr_val", 64'(rd_valid), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr_stale", 64'(rd_valid), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_fifo_ctrl.md
SRAM_FIFO_CTRL -- requirements
Module: sram_fifo_ctrl

Interface
REQ-001 Parameter DWIDTH, default 32, data word width.
REQ-002 Parameter AWIDTH, default 5, SRAM address width; DEPTH = 2**AWIDTH.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high; ports clk_in and rst_in.
REQ-004 clk_in  input  1  sole clock, all state on rising edge.
REQ-005 rst_in  input  1  synchronous active-high reset.
REQ-006 wr_valid_in  input  1  producer offers wr_data_in.
REQ-007 wr_data_in  input  DWIDTH  write word.
REQ-008 wr_ready_out  output  1  block accepts a word this cycle.
REQ-009 rd_valid_out  output  1  rd_data_out holds a valid word.
REQ-010 rd_data_out  output  DWIDTH  head-of-queue word.
REQ-011 rd_ready_in  input  1  consumer takes the word.
REQ-012 count_out  output  AWIDTH+1  total occupancy (SRAM + in-flight + output buffer).
REQ-013 full_out / empty_out  output  1 each  count_out == DEPTH / count_out == 0.
REQ-014 sram_en_a_out, sram_we_a_out  output  1 each  SRAM port A (write) enable/write-enable.
REQ-015 sram_addr_a_out  output  AWIDTH; sram_d_a_out  output  DWIDTH  port A address/data.
REQ-016 sram_en_b_out, sram_we_b_out  output  1 each  SRAM port B (read) enable; we_b tied 0.
REQ-017 sram_addr_b_out  output  AWIDTH; sram_d_b_in  input  DWIDTH  port B address / registered read data.

Function
REQ-018 Push = wr_valid_in & wr_ready_out; pop = rd_valid_out & rd_ready_in.
REQ-019 wr_ready_out SHALL equal !full_out from registered count; no write while full, even if pop occurs in the same cycle.
REQ-020 On push: sram_en_a_out = sram_we_a_out = 1, sram_addr_a_out = wptr, sram_d_a_out = wr_data_in (combinational); wptr increments, wrapping DEPTH-1 -> 0.
REQ-021 mem_cnt (words in SRAM not yet read) SHALL increment at the edge ending a push cycle; reads are only issued when mem_cnt > 0, so read-during-write of the same address never occurs.
REQ-022 SRAM read latency is 1 cycle: data for a read issued in cycle N is valid on sram_d_b_in in cycle N+1 and SHALL be captured into the output buffer at the end of cycle N+1; an inflight flag tracks this.
REQ-023 Output buffer holds 2 entries; states EMPTY (0), ONE (1), TWO (2); rd_valid_out = state != EMPTY; rd_data_out = oldest entry, registered.
REQ-024 Transitions: +1 on capture, -1 on pop, unchanged on both/neither; TWO never receives a capture without a same-cycle pop.
REQ-025 Read issue (sram_en_b_out = 1, addr = rptr, rptr wraps) SHALL occur when mem_cnt > 0 and ob_cnt + inflight - pop + 1 <= 2.
REQ-026 count_out SHALL increment on push, decrement on pop, hold on both/neither; range 0..DEPTH.
REQ-027 Latency: word pushed in cycle 0 into empty block -> rd_valid_out high in cycle 3.
REQ-028 Steady state with rd_ready_in held 1 and continuous pushes: one word out per cycle, order preserved.
REQ-029 rd_data_out SHALL remain stable while rd_valid_out = 1 and rd_ready_in = 0.

Reset
REQ-030 rst_in SHALL clear wptr, rptr, mem_cnt, inflight, ob state to EMPTY, count_out to 0; empty_out = 1, full_out = 0, wr_ready_out = 1, rd_valid_out = 0, all sram_en/we outputs 0.
REQ-031 Reset mid-operation SHALL discard in-flight read data and all queued words; SRAM contents are don't-care.
REQ-032 During the reset cycle no push is accepted and no read issued.

Structure
REQ-033 Shared package sram_fifo_pkg SHALL hold the ob state enum (OB_EMPTY, OB_ONE, OB_TWO) and default DWIDTH/AWIDTH constants.
REQ-034 The 2-entry output buffer SHALL be a sub-module fifo_skid2; the SRAM itself is instantiated by the parent, not inside this block.

Verification
REQ-035 Single word: push 0xA5A5_0001 in cycle 0, rd_ready_in = 1 -> rd_valid_out cycle 3 with 0xA5A5_0001, then empty_out = 1.
REQ-036 Fill: AWIDTH=5, push 32 words, rd_ready_in = 0 -> full_out = 1, count_out = 32, wr_ready_out = 0; 33rd offered word not accepted.
REQ-037 Wrap: push/pop 100 incrementing words with random rd_ready_in -> output sequence 0..99 in order, pointers wrap without loss.
REQ-038 Backpressure: output TWO, rd_ready_in = 0 for 5 cycles -> rd_data_out stable, no read issued, count_out unchanged.
REQ-039 Full + pop: full, rd_ready_in = 1 and wr_valid_in = 1 same cycle -> write refused that cycle, accepted next, count_out 32 -> 31 -> 32.
REQ-040 Reset mid-read: assert rst_in the cycle after a read issue -> next cycle count_out = 0, rd_valid_out = 0, stale word never appears.
